up_bus_arbiter: RTL

//  Shares the single up_* register bus (up_wr/up_rd/up_addr/up_data_wr/up_data_rd/up_wait) between NUM_REQ masters.

---
 rtl/up_bus_pkg.sv | 19 +
 rtl/up_bus_arbiter_rr_arbiter.sv | 30 +++
 rtl/up_bus_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/up_bus_pkg.sv
// Shared definitions for the up_* register bus arbiter: FSM encoding,
// the read data returned on a timed-out access, and an index-width helper.
package up_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Index width that stays at least one bit wide when only one master exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/up_bus_arbiter_rr_arbiter.sv
// Combinational round-robin search: first active master at or after ptr,
// wrapping to the lowest active index when nothing at or above ptr is active.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GW      = 1
) (
    input  logic [NUM_REQ-1:0] active,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      grant,
    output logic               any_active
);

    always_comb begin
        grant      = '0;
        any_active = 1'b0;
        // Lowest active index overall serves as the wrap-around fallback.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                grant      = GW'(i);
                any_active = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (active[i] && (GW'(i) >= ptr)) begin
                grant = GW'(i);
            end
        end
    end

endmodule

// File: rtl/up_bus_arbiter.sv
// Shares the single up_* register bus between NUM_REQ masters: round-robin
// grant, one access in flight, per-access wait timeout with sticky error.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no access in flight; grant next active master from rr_ptr
//   ST_ISSUE | one-cycle up_wr/up_rd strobe with latched addr/data
//   ST_WAIT  | count cycles until slave completes or TIMEOUT expires
//   ST_DONE  | drop req_wait of the granted master for one cycle
module up_bus_arbiter
    import up_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      up_clk,
    input  logic                      up_rst_n,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ-1:0]        req_rd,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_wait,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      up_wr,
    output logic                      up_rd,
    output logic [ADDR_W-1:0]         up_addr,
    output logic [DATA_W-1:0]         up_data_wr,
    input  logic [DATA_W-1:0]         up_data_rd,
    input  logic                      up_wait,
    input  logic                      err_clr,
    output logic                      err_timeout,
    output logic                      busy
);

    localparam int GW = idx_w(NUM_REQ);

    state_t              state;
    state_t              state_nxt;
    logic [NUM_REQ-1:0]  active;
    logic [GW-1:0]       arb_grant;
    logic                any_active;
    logic [GW-1:0]       grant_q;
    logic [GW-1:0]       rr_ptr;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                op_wr_q;
    logic [7:0]          wait_cnt;
    logic                cmpl_ok;
    logic                tmo_hit;

    assign active  = req_rd | req_wr;
    assign cmpl_ok = (wait_cnt >= 8'(MIN_LAT - 1)) && !up_wait;
    assign tmo_hit = (wait_cnt == 8'(TIMEOUT));

    rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
        .active     (active),
        .ptr        (rr_ptr),
        .grant      (arb_grant),
        .any_active (any_active)
    );

    always_ff @(posedge up_clk or negedge up_rst_n) begin
        if (!up_rst_n) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any_active) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (cmpl_ok || tmo_hit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rst_n) begin
        if (!up_rst_n) begin
            grant_q   <= '0;
            rr_ptr    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            wait_cnt  <= '0;
            req_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: if (any_active) begin
                    grant_q <= arb_grant;
                    addr_q  <= req_addr[arb_grant*ADDR_W +: ADDR_W];
                    wdata_q <= req_wdata[arb_grant*DATA_W +: DATA_W];
                    op_wr_q <= req_wr[arb_grant];   // rd+wr together is a write
                end
                ST_ISSUE: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (cmpl_ok)      req_rdata <= up_data_rd;
                    else if (tmo_hit) req_rdata <= DATA_W'(TIMEOUT_RDATA);
                end
                ST_DONE: rr_ptr <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge up_clk or negedge up_rst_n) begin
        if (!up_rst_n)                                       err_timeout <= 1'b0;
        else if (state == ST_WAIT && !cmpl_ok && tmo_hit)    err_timeout <= 1'b1;
        else if (err_clr)                                    err_timeout <= 1'b0;
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_wait[i] = active[i] & ~((state == ST_DONE) && (grant_q == GW'(i)));
        end
    end

    assign up_wr      = (state == ST_ISSUE) &&  op_wr_q;
    assign up_rd      = (state == ST_ISSUE) && !op_wr_q;
    assign up_addr    = (state == ST_IDLE) ? '0 : addr_q;
    assign up_data_wr = (state == ST_IDLE) ? '0 : wdata_q;
    assign busy       = (state != ST_IDLE);

endmodule
